// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 unit: register indices, ExcCode values, field positions.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package cp0_pkg;

    // Default parameter values for the top level
    localparam logic [31:0] PRID_DEFAULT       = 32'h1809_0001;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

    // CP0 register indices (mfc0/mtc0 rd field)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // SR field positions
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_IM_LO = 10;
    localparam int SR_IM_HI = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // Return address for an instruction: a delay-slot instruction restarts at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] ret;
        ret = bd ? (pc - 32'd4) : pc;
        return ret & ~32'd3;
    endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// Count/Compare timer: free-running Count, Compare match raises sticky TI.
// Latency: TI sets on the edge where Count==Compare (visible the cycle after the match).
// Backpressure: none; writes always accepted when we_i is high.
// Ports: clk, reset (sync, active-high); we_i/waddr_i/wdata_i mtc0 write port;
//        count_o, compare_o current register values; ti_o timer interrupt.
module cp0_count_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ti_d      = ti_q;
        // A written Count is loaded as-is, not incremented that cycle
        if (we_i && waddr_i == REG_COUNT) begin
            count_d = wdata_i;
        end
        // Compare write acknowledges the timer interrupt; otherwise TI is sticky
        if (we_i && waddr_i == REG_COMPARE) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end else if (count_q == compare_q && compare_q != 32'd0) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, interrupt/exception decision, eret address.
// Latency: IntReq is combinational (same cycle); register updates land on the next clk edge.
// Backpressure: none; an mtc0 coinciding with IntReq is dropped.
// Ports: clk, reset (sync, active-high); A1/DOut mfc0 read; A2/DIn/WE mtc0 write;
//        PC/BD/ExcCodeIn from M stage; HWInt[7:2] IRQ lines; EXLClr eret;
//        IntReq flush/redirect; HandlerPC entry address; EPCOut return address.
// Optional: define CP0_COUNT_EN to add Count (reg 9) / Compare (reg 11) with TI on HWInt[7].
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCodeIn,
    input  logic [7:2]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    // SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    // EPC
    logic [31:0] epc_q, epc_d;

    logic [31:0] count_w, compare_w;
    logic        ti_w;
    logic [7:2]  hw_eff;
    logic        int_pend, exc_pend;
    logic [31:0] sr_val, cause_val;

`ifdef CP0_COUNT_EN
    cp0_count_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .we_i      (WE & ~IntReq),
        .waddr_i   (A2),
        .wdata_i   (DIn),
        .count_o   (count_w),
        .compare_o (compare_w),
        .ti_o      (ti_w)
    );
`else
    assign count_w   = 32'd0;
    assign compare_w = 32'd0;
    assign ti_w      = 1'b0;
`endif

    // Pending decision uses the live lines, not the latched IP copy
    always_comb begin
        hw_eff    = HWInt;
        hw_eff[7] = HWInt[7] | ti_w;
        int_pend  = (|(hw_eff & im_q)) & ie_q & ~exl_q;
        exc_pend  = (ExcCodeIn != EXC_INT) & ~exl_q;
    end

    assign IntReq = int_pend | exc_pend;

    always_comb begin
        sr_val                       = 32'd0;
        sr_val[SR_IM_HI:SR_IM_LO]    = im_q;
        sr_val[SR_EXL]               = exl_q;
        sr_val[SR_IE]                = ie_q;
        cause_val                    = 32'd0;
        cause_val[CAUSE_BD]          = bd_q;
        cause_val[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
        cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    end

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = hw_eff;
        exc_d = exc_q;
        epc_d = epc_q;
        if (IntReq) begin
            // Entry: interrupt outranks a simultaneous exception; mtc0 is dropped
            exl_d = 1'b1;
            exc_d = int_pend ? EXC_INT : ExcCodeIn;
            bd_d  = BD;
            epc_d = epc_of(PC, BD);
        end else begin
            if (EXLClr) begin
                exl_d = 1'b0;
            end
            if (WE) begin
                case (A2)
                    REG_SR: begin
                        im_d  = DIn[SR_IM_HI:SR_IM_LO];
                        exl_d = DIn[SR_EXL];
                        ie_d  = DIn[SR_IE];
                    end
                    REG_EPC: epc_d = DIn & ~32'd3;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= 6'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 32'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        case (A1)
            REG_COUNT:   DOut = count_w;
            REG_COMPARE: DOut = compare_w;
            REG_SR:      DOut = sr_val;
            REG_CAUSE:   DOut = cause_val;
            REG_EPC:     DOut = epc_q;
            REG_PRID:    DOut = PRID;
            default:     DOut = 32'd0;
        endcase
    end

    assign HandlerPC = HANDLER_PC;
    assign EPCOut    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: inputs driven on negedge, outputs sampled 1ns later.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCodeIn;
    logic [7:2]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] HandlerPC, EPCOut, DOut;

    int n_cmp = 0;
    int n_err = 0;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PC        (PC),
        .BD        (BD),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .HandlerPC (HandlerPC),
        .EPCOut    (EPCOut),
        .DOut      (DOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        WE = 1'b1; A2 = idx; DIn = val;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        @(negedge clk);
        A1 = idx;
        #1 chk(tag, DOut, exp);
    endtask

    task automatic eret();
        @(negedge clk);
        EXLClr = 1'b1;
        @(negedge clk);
        EXLClr = 1'b0;
    endtask

    initial begin
        logic        found;
        logic [31:0] cnt;
        reset = 1'b1; A1 = 5'd12; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; PC = 32'd0;
        BD = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_intreq", {31'd0, IntReq}, 32'd0);
        chk("rst_sr", DOut, 32'd0);
        chk("rst_epcout", EPCOut, 32'd0);
        chk("handler_pc", HandlerPC, 32'h0000_4180);
        rd(5'd13, 32'd0, "rst_cause");

        // 1: interrupt on HWInt[2]
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, 32'h0000_0401, "t1_sr_wr");
        @(negedge clk);
        PC = 32'h0000_3010; HWInt = 6'b000001;
        #1 chk("t1_intreq", {31'd0, IntReq}, 32'd1);
        @(negedge clk);
        HWInt = 6'd0; A1 = 5'd13;
        #1 chk("t1_masked", {31'd0, IntReq}, 32'd0);
        chk("t1_cause", DOut, 32'h0000_0400);
        rd(5'd12, 32'h0000_0403, "t1_sr_exl");
        rd(5'd14, 32'h0000_3010, "t1_epc");
        chk("t1_epcout", EPCOut, 32'h0000_3010);
        eret();
        rd(5'd12, 32'h0000_0401, "t1_eret_sr");

        // 2: overflow in a delay slot, concurrent mtc0 EPC dropped
        @(negedge clk);
        BD = 1'b1; PC = 32'h0000_3024; ExcCodeIn = 5'd12;
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234;
        #1 chk("t2_intreq", {31'd0, IntReq}, 32'd1);
        @(negedge clk);
        BD = 1'b0; ExcCodeIn = 5'd0; WE = 1'b0; A1 = 5'd13;
        #1 chk("t2_cause", DOut, 32'h8000_0030);
        rd(5'd14, 32'h0000_3020, "t2_epc");
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, 32'h8000_0030, "t5_cause_ro");
        eret();
        eret();
        rd(5'd12, 32'h0000_0401, "t2_eret_twice");

        // 3: interrupt beats simultaneous RI
        @(negedge clk);
        HWInt = 6'b000001; ExcCodeIn = 5'd10; PC = 32'h0000_3100;
        #1 chk("t3_intreq", {31'd0, IntReq}, 32'd1);
        @(negedge clk);
        HWInt = 6'd0; ExcCodeIn = 5'd0; A1 = 5'd13;
        #1 chk("t3_cause", DOut, 32'h0000_0400);
        rd(5'd14, 32'h0000_3100, "t3_epc");

        // 4: EXL masks everything until eret
        @(negedge clk);
        HWInt = 6'b000001; ExcCodeIn = 5'd4; PC = 32'h0000_3200;
        #1 chk("t4_exl_mask", {31'd0, IntReq}, 32'd0);
        @(negedge clk);
        EXLClr = 1'b1;
        #1 chk("t4_eret_cycle", {31'd0, IntReq}, 32'd0);
        @(negedge clk);
        EXLClr = 1'b0;
        #1 chk("t4_after_eret", {31'd0, IntReq}, 32'd1);
        @(negedge clk);
        HWInt = 6'd0; ExcCodeIn = 5'd0;
        #1 chk("t4_reentered", {31'd0, IntReq}, 32'd0);
        rd(5'd14, 32'h0000_3200, "t4_epc");
        eret();

        // 5: EPC alignment, read-during-write, misc reads, SR masking
        mtc0(5'd14, 32'h0000_3007);
        rd(5'd14, 32'h0000_3004, "t5_epc_align");
        @(negedge clk);
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000; A1 = 5'd14;
        #1 chk("t5_rdw_old", DOut, 32'h0000_3004);
        @(negedge clk);
        WE = 1'b0;
        #1 chk("t5_rdw_new", DOut, 32'h0000_5000);
        rd(5'd15, 32'h1809_0001, "t5_prid");
        rd(5'd20, 32'd0, "t5_unmapped");
`ifndef CP0_COUNT_EN
        rd(5'd9, 32'd0, "t5_count_off");
`endif
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, 32'h0000_FC03, "t5_sr_mask");
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, 32'h0000_0401, "t5_sr_restore");

        // Reset in the middle of a handler
        @(negedge clk);
        ExcCodeIn = 5'd5; PC = 32'h0000_3300;
        #1 chk("rst_mid_take", {31'd0, IntReq}, 32'd1);
        @(negedge clk);
        ExcCodeIn = 5'd0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; A1 = 5'd12;
        #1 chk("rst_mid_sr", DOut, 32'd0);
        chk("rst_mid_epc", EPCOut, 32'd0);
        rd(5'd13, 32'd0, "rst_mid_cause");

`ifdef CP0_COUNT_EN
        // 6: Count/Compare timer interrupt on HWInt[7]
        mtc0(5'd9, 32'h0000_1000);
        mtc0(5'd11, 32'd20);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        A1 = 5'd9;
        found = 1'b0;
        cnt = 32'd0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (IntReq) begin
                found = 1'b1;
                cnt = DOut;
            end
        end
        chk("t6_ti_seen", {31'd0, found}, 32'd1);
        chk("t6_count_at_ti", cnt, 32'd21);
        rd(5'd13, 32'h0000_8000, "t6_ip7_set");
        mtc0(5'd11, 32'd0);
        rd(5'd13, 32'd0, "t6_ip7_clr");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
